// File: rtl/frame_capture_buffer.sv
// Frame capture stage: shifts in decoded bits, checks the preamble and constant
// fields, and publishes a payload window into a byte-addressable shadow buffer.
module frame_capture_buffer #(
    parameter int unsigned                FRAME_BITS     = 192,
    parameter int unsigned                PREAMBLE_BITS  = 32,
    parameter logic [PREAMBLE_BITS-1:0]   PREAMBLE_VALUE = 32'hAAAAAAAA,
    parameter int unsigned                CONST_OFFSET   = 64,
    parameter int unsigned                CONST_BITS     = 32,
    parameter logic [CONST_BITS-1:0]      CONST_VALUE    = 32'h0DFFFFFE,
    parameter int unsigned                PAYLOAD_OFFSET = 96,
    parameter int unsigned                PAYLOAD_BYTES  = 12,
    parameter int unsigned                ADDR_BITS      = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 frame_begin,
    input  logic                 bit_strobe,
    input  logic                 bit_data,
    input  logic                 hold,
    input  logic [ADDR_BITS-1:0] address,
    output logic [7:0]           read_data,
    output logic                 full,
    output logic                 valid,
    output logic                 overrun,
    output logic [7:0]           frame_count,
    output logic [7:0]           error_count
);

    localparam int unsigned CNT_W     = $clog2(FRAME_BITS + 1);
    // Frame bit i sits at register position FRAME_BITS-1-i once the frame is complete.
    localparam int unsigned PRE_MSB   = FRAME_BITS - 1;
    localparam int unsigned CONST_MSB = FRAME_BITS - 1 - CONST_OFFSET;
    localparam int unsigned PAY_MSB   = FRAME_BITS - 1 - PAYLOAD_OFFSET;

    localparam logic [CNT_W-1:0]     LAST_BIT    = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0]     FRAME_END   = CNT_W'(FRAME_BITS);
    localparam logic [ADDR_BITS-1:0] STATUS_ADDR = '1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RECEIVE = 2'd1,
        S_CHECK   = 2'd2
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      bit_count;
    logic [FRAME_BITS-1:0] frame_sr;
    logic [7:0]            shadow [PAYLOAD_BYTES];
    logic                  last_check_ok;
    logic                  check_ok_c;

    assign check_ok_c = (frame_sr[PRE_MSB -: PREAMBLE_BITS] == PREAMBLE_VALUE) &&
                        (frame_sr[CONST_MSB -: CONST_BITS] == CONST_VALUE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= S_IDLE;
            bit_count     <= '0;
            frame_sr      <= '0;
            full          <= 1'b0;
            valid         <= 1'b0;
            overrun       <= 1'b0;
            frame_count   <= 8'd0;
            error_count   <= 8'd0;
            last_check_ok <= 1'b0;
            for (int unsigned k = 0; k < PAYLOAD_BYTES; k++) begin
                shadow[k] <= 8'h00;
            end
        end else begin
            // Receive sequencing; a new frame_begin wins over any strobe in the same cycle.
            if (frame_begin) begin
                state     <= S_RECEIVE;
                bit_count <= '0;
                full      <= 1'b0;
            end else begin
                case (state)
                    S_RECEIVE: begin
                        if (bit_strobe && (bit_count < FRAME_END)) begin
                            frame_sr  <= {frame_sr[FRAME_BITS-2:0], bit_data};
                            bit_count <= bit_count + CNT_W'(1);
                            if (bit_count == LAST_BIT) begin
                                full  <= 1'b1;
                                state <= S_CHECK;
                            end
                        end
                    end
                    S_CHECK: state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end

            // The completed frame is judged even if a new frame_begin arrives in CHECK.
            if (state == S_CHECK) begin
                last_check_ok <= check_ok_c;
                if (check_ok_c) begin
                    if (hold) begin
                        overrun <= 1'b1;
                    end else begin
                        for (int unsigned k = 0; k < PAYLOAD_BYTES; k++) begin
                            shadow[k] <= frame_sr[PAY_MSB - 8*k -: 8];
                        end
                        valid       <= 1'b1;
                        frame_count <= frame_count + 8'd1;
                    end
                end else if (error_count != 8'hFF) begin
                    error_count <= error_count + 8'd1;
                end
            end
        end
    end

    // Byte-wide read port: payload bytes, status at the top address, zero elsewhere.
    always_comb begin
        read_data = 8'h00;
        for (int unsigned k = 0; k < PAYLOAD_BYTES; k++) begin
            if (address == ADDR_BITS'(k)) begin
                read_data = shadow[k];
            end
        end
        if (address == STATUS_ADDR) begin
            read_data = {3'b000, hold, last_check_ok, overrun, valid, full};
        end
    end

endmodule

// File: tb/tb_frame_capture_buffer.sv
// Bench for frame_capture_buffer: default instance checked every cycle against a
// frame-level model, plus a small-frame instance for counter saturation and wrap.
module tb_frame_capture_buffer;

    localparam int unsigned FB = 192;
    localparam int unsigned NB = 12;
    localparam logic [31:0] PRE  = 32'hAAAAAAAA;
    localparam logic [31:0] CST  = 32'h0DFFFFFE;

    logic       clock = 1'b0;
    logic       reset, frame_begin, bit_strobe, bit_data, hold;
    logic [3:0] address;
    logic [7:0] read_data, frame_count, error_count;
    logic       full, valid, overrun;

    logic       s_reset, s_begin, s_strobe, s_data;
    logic [1:0] s_address;
    logic [7:0] s_read_data, s_frame_count, s_error_count;
    logic       s_full, s_valid, s_overrun;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state, kept per frame bit index
    bit         m_rx, m_pend, m_full, m_valid, m_ovr, m_ok;
    int         m_cnt, m_fc, m_ec;
    bit         m_bits [FB];
    logic [7:0] m_shadow [NB];

    bit         tx_bits [FB];
    logic [7:0] tx_pay [NB];
    logic [7:0] want [NB];

    frame_capture_buffer dut (
        .clock(clock), .reset(reset), .frame_begin(frame_begin),
        .bit_strobe(bit_strobe), .bit_data(bit_data), .hold(hold),
        .address(address), .read_data(read_data), .full(full), .valid(valid),
        .overrun(overrun), .frame_count(frame_count), .error_count(error_count)
    );

    frame_capture_buffer #(
        .FRAME_BITS(32), .PREAMBLE_BITS(8), .PREAMBLE_VALUE(8'hA5),
        .CONST_OFFSET(8), .CONST_BITS(8), .CONST_VALUE(8'h3C),
        .PAYLOAD_OFFSET(16), .PAYLOAD_BYTES(2), .ADDR_BITS(2)
    ) dut_s (
        .clock(clock), .reset(s_reset), .frame_begin(s_begin),
        .bit_strobe(s_strobe), .bit_data(s_data), .hold(1'b0),
        .address(s_address), .read_data(s_read_data), .full(s_full), .valid(s_valid),
        .overrun(s_overrun), .frame_count(s_frame_count), .error_count(s_error_count)
    );

    initial forever #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_rd(input logic [3:0] a);
        if (int'(a) < int'(NB)) return m_shadow[int'(a)];
        if (a == 4'hF) return {3'b000, hold, m_ok, m_ovr, m_valid, m_full};
        return 8'h00;
    endfunction

    // Advance the model by one clock edge using the inputs currently driven
    task automatic model_step();
        logic [31:0] p, c;
        logic [7:0]  b;
        if (reset) begin
            m_rx = 0; m_pend = 0; m_full = 0; m_valid = 0; m_ovr = 0; m_ok = 0;
            m_cnt = 0; m_fc = 0; m_ec = 0;
            for (int k = 0; k < NB; k++) m_shadow[k] = 8'h00;
            return;
        end
        if (m_pend) begin
            p = 32'h0; c = 32'h0;
            for (int i = 0; i < 32; i++) begin
                p = {p[30:0], m_bits[i]};
                c = {c[30:0], m_bits[64+i]};
            end
            m_ok = (p == PRE) && (c == CST);
            if (m_ok) begin
                if (hold) m_ovr = 1;
                else begin
                    for (int k = 0; k < NB; k++) begin
                        b = 8'h00;
                        for (int j = 0; j < 8; j++) b = {b[6:0], m_bits[96 + 8*k + j]};
                        m_shadow[k] = b;
                    end
                    m_valid = 1;
                    m_fc = (m_fc + 1) % 256;
                end
            end else if (m_ec < 255) begin
                m_ec++;
            end
            m_pend = 0;
        end
        if (frame_begin) begin
            m_rx = 1; m_cnt = 0; m_full = 0;
        end else if (m_rx && bit_strobe) begin
            m_bits[m_cnt] = bit_data;
            m_cnt++;
            if (m_cnt == int'(FB)) begin
                m_full = 1; m_rx = 0; m_pend = 1;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
        check_eq("full",        32'(full),        32'(m_full));
        check_eq("valid",       32'(valid),       32'(m_valid));
        check_eq("overrun",     32'(overrun),     32'(m_ovr));
        check_eq("frame_count", 32'(frame_count), 32'(m_fc));
        check_eq("error_count", 32'(error_count), 32'(m_ec));
        check_eq("read_data",   32'(read_data),   32'(exp_rd(address)));
        frame_begin = 0; bit_strobe = 0; s_begin = 0; s_strobe = 0;
    endtask

    task automatic rnd_inputs();
        address  = 4'($urandom);
        bit_data = 1'($urandom);
        if ($urandom_range(0, 15) == 0) hold = ~hold;
    endtask

    task automatic build_frame(input logic [31:0] p, input logic [31:0] c);
        for (int i = 0; i < FB; i++) tx_bits[i] = 1'($urandom);
        for (int i = 0; i < 32; i++) begin
            tx_bits[i]      = p[31-i];
            tx_bits[64 + i] = c[31-i];
        end
        for (int k = 0; k < NB; k++)
            for (int j = 0; j < 8; j++) tx_bits[96 + 8*k + j] = tx_pay[k][7-j];
    endtask

    task automatic begin_frame();
        frame_begin = 1;
        tick();
    endtask

    task automatic send_bits(input int first, input int n, input bit rnd);
        int gap;
        for (int i = first; i < first + n; i++) begin
            gap = (rnd && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            for (int g = 0; g < gap; g++) begin
                rnd_inputs();
                tick();
            end
            if (rnd) rnd_inputs();
            bit_strobe = 1;
            bit_data   = (i < int'(FB)) ? tx_bits[i] : 1'($urandom);
            tick();
        end
    endtask

    task automatic run_frame(input logic [31:0] p, input logic [31:0] c);
        build_frame(p, c);
        begin_frame();
        send_bits(0, FB, 0);
        tick();
        tick();
    endtask

    task automatic new_payload();
        for (int k = 0; k < NB; k++) tx_pay[k] = 8'($urandom);
    endtask

    task automatic check_bytes(input string tag);
        for (int k = 0; k < NB; k++) begin
            address = 4'(k);
            tick();
            check_eq(tag, 32'(read_data), 32'(want[k]));
        end
    endtask

    task automatic s_send(input logic [31:0] w);
        s_begin = 1;
        tick();
        for (int i = 0; i < 32; i++) begin
            s_strobe = 1;
            s_data   = w[31-i];
            tick();
        end
        tick();
        tick();
    endtask

    initial begin
        logic [31:0] p, c;
        int          fc0, ec0;

        reset = 1; frame_begin = 0; bit_strobe = 0; bit_data = 0; hold = 0; address = 4'hF;
        s_reset = 1; s_begin = 0; s_strobe = 0; s_data = 0; s_address = 2'd0;
        tick();
        tick();
        check_eq("rst_full",   32'(full), 32'd0);
        check_eq("rst_valid",  32'(valid), 32'd0);
        check_eq("rst_status", 32'(read_data), 32'h00);
        check_eq("rst_fc",     32'(frame_count), 32'd0);
        reset = 0; s_reset = 0;

        // Good frame with payload 01..0C
        for (int k = 0; k < NB; k++) begin tx_pay[k] = 8'(k + 1); want[k] = 8'(k + 1); end
        build_frame(PRE, CST);
        begin_frame();
        send_bits(0, FB, 0);
        check_eq("good_full_n1",  32'(full), 32'd1);
        check_eq("good_valid_n1", 32'(valid), 32'd0);
        tick();
        check_eq("good_valid_n2", 32'(valid), 32'd1);
        check_bytes("good_byte");
        address = 4'hF; tick();
        check_eq("good_status", 32'(read_data), 32'h0B);
        check_eq("good_fc",     32'(frame_count), 32'd1);
        for (int a = 12; a < 15; a++) begin
            address = 4'(a); tick();
            check_eq("unused_addr", 32'(read_data), 32'h00);
        end

        // Corrupted preamble after reset
        reset = 1; tick(); reset = 0;
        new_payload();
        run_frame(32'hAAAAAAAB, CST);
        check_eq("badpre_valid", 32'(valid), 32'd0);
        check_eq("badpre_ec",    32'(error_count), 32'd1);
        address = 4'hF; tick();
        check_eq("badpre_status", 32'(read_data), 32'h01);
        address = 4'h0; tick();
        check_eq("badpre_byte0", 32'(read_data), 32'h00);

        // Hold freezes the shadow buffer and flags overrun
        reset = 1; tick(); reset = 0;
        new_payload(); for (int k = 0; k < NB; k++) want[k] = tx_pay[k];
        run_frame(PRE, CST);
        hold = 1;
        new_payload(); tx_pay[0] = ~want[0];
        run_frame(PRE, CST);
        check_bytes("hold_keeps_a");
        check_eq("hold_overrun", 32'(overrun), 32'd1);
        check_eq("hold_fc",      32'(frame_count), 32'd1);
        hold = 0;
        new_payload(); for (int k = 0; k < NB; k++) want[k] = tx_pay[k];
        run_frame(PRE, CST);
        check_bytes("release_c");
        check_eq("release_fc",      32'(frame_count), 32'd2);
        check_eq("release_overrun", 32'(overrun), 32'd1);

        // Restart after 100 bits, then a restart coincident with a strobe
        new_payload(); build_frame(PRE, CST);
        begin_frame(); send_bits(0, 100, 0);
        new_payload(); for (int k = 0; k < NB; k++) want[k] = tx_pay[k];
        run_frame(PRE, CST);
        check_bytes("restart100");
        new_payload(); for (int k = 0; k < NB; k++) want[k] = tx_pay[k];
        build_frame(PRE, CST);
        begin_frame(); send_bits(0, 50, 0);
        frame_begin = 1; bit_strobe = 1; bit_data = ~tx_bits[0]; tick();
        send_bits(0, FB, 0); tick(); tick();
        check_bytes("restart_coincident");
        check_eq("restart_fc", 32'(frame_count), 32'd4);
        check_eq("restart_ec", 32'(error_count), 32'd0);

        // Extra strobes are ignored and only one check happens
        fc0 = m_fc; ec0 = m_ec;
        new_payload(); build_frame(PRE, CST);
        begin_frame(); send_bits(0, 200, 0); tick(); tick();
        check_eq("extra_full", 32'(full), 32'd1);
        check_eq("extra_fc",   32'(frame_count), 32'(fc0 + 1));
        check_eq("extra_ec",   32'(error_count), 32'(ec0));
        begin_frame();
        check_eq("extra_full_clr", 32'(full), 32'd0);

        // Reset mid-frame
        send_bits(0, 150, 0);
        reset = 1; address = 4'hF; tick(); reset = 0;
        check_eq("midrst_status", 32'(read_data), 32'h00);
        check_eq("midrst_valid",  32'(valid), 32'd0);
        check_eq("midrst_ec",     32'(error_count), 32'd0);

        // Randomized frames with gaps, hold toggling, corruption and aborts
        for (int f = 0; f < 40; f++) begin
            p = PRE; c = CST;
            case ($urandom_range(0, 3))
                0: p = p ^ (32'h1 << $urandom_range(0, 31));
                1: c = c ^ (32'h1 << $urandom_range(0, 31));
                default: ;
            endcase
            new_payload(); build_frame(p, c);
            if ($urandom_range(0, 7) == 0) begin
                begin_frame(); send_bits(0, int'($urandom_range(1, 191)), 1);
            end
            begin_frame();
            send_bits(0, int'(FB) + int'($urandom_range(0, 4)), 1);
            rnd_inputs(); tick();
            rnd_inputs(); tick();
        end
        hold = 0;

        // Small instance: error counter saturation
        for (int i = 0; i < 300; i++) begin
            if (i % 2 == 0) s_send({8'hA5 ^ (8'h1 << $urandom_range(0, 7)), 8'h3C, 16'($urandom)});
            else            s_send({8'hA5, 8'h3C ^ (8'h1 << $urandom_range(0, 7)), 16'($urandom)});
            if (i == 0)   check_eq("sat_ec_1",   32'(s_error_count), 32'd1);
            if (i == 254) check_eq("sat_ec_255", 32'(s_error_count), 32'd255);
        end
        check_eq("sat_ec_hold", 32'(s_error_count), 32'd255);
        check_eq("sat_fc",      32'(s_frame_count), 32'd0);
        check_eq("sat_valid",   32'(s_valid), 32'd0);

        // Small instance: frame counter wrap
        for (int i = 0; i < 256; i++) begin
            s_send({8'hA5, 8'h3C, 8'(i), 8'(i) ^ 8'h5A});
            if (i == 0)   check_eq("wrap_fc_1",   32'(s_frame_count), 32'd1);
            if (i == 254) check_eq("wrap_fc_255", 32'(s_frame_count), 32'd255);
        end
        check_eq("wrap_fc_0",  32'(s_frame_count), 32'd0);
        check_eq("wrap_valid", 32'(s_valid), 32'd1);
        check_eq("wrap_ec",    32'(s_error_count), 32'd255);
        s_address = 2'd0; tick();
        check_eq("wrap_byte0", 32'(s_read_data), 32'hFF);
        s_address = 2'd1; tick();
        check_eq("wrap_byte1", 32'(s_read_data), 32'hA5);
        s_address = 2'd2; tick();
        check_eq("wrap_unused", 32'(s_read_data), 32'h00);
        s_address = 2'd3; tick();
        check_eq("wrap_status", 32'(s_read_data), 32'h0B);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/frame_capture_buffer.md
Name: frame_capture_buffer

Overview:
Parametrised frame capture stage sitting between the Manchester state machine and the chip pins. It shifts in decoded bits, checks a preamble field and a constant field at configurable offsets, and publishes a configurable payload window into a shadow byte buffer. The buffer is read byte-wise by address. A hold input freezes the shadow buffer so the microcontroller can read a coherent frame while reception continues.

Parameters:
FRAME_BITS, 192, total bits per frame; first received bit is frame bit 0
PREAMBLE_BITS, 32, width of the preamble field at frame bits 0..PREAMBLE_BITS-1
PREAMBLE_VALUE, 32'hAAAAAAAA, required preamble; bit 0 is received first and maps to the MSB
CONST_OFFSET, 64, frame bit index of the first bit of the constant field
CONST_BITS, 32, width of the constant field
CONST_VALUE, 32'h0DFFFFFE, required constant; first received bit maps to the MSB
PAYLOAD_OFFSET, 96, frame bit index of the first bit of payload byte 0
PAYLOAD_BYTES, 12, number of published bytes; must satisfy PAYLOAD_BYTES < 2**ADDR_BITS
ADDR_BITS, 4, read address width

Ports:
clock  input  1  system clock; all state changes on its rising edge
reset  input  1  synchronous, active-high reset
frame_begin  input  1  one-cycle pulse marking the start of a transmission
bit_strobe  input  1  one-cycle pulse; bit_data is valid in this cycle
bit_data  input  1  decoded data bit
hold  input  1  1 = shadow buffer frozen (reader busy)
address  input  ADDR_BITS  read address
read_data  output  8  addressed byte (combinational from registers)
full  output  1  FRAME_BITS bits received in the current frame
valid  output  1  at least one good frame has been published since reset
overrun  output  1  sticky: a good frame was dropped because hold was set
frame_count  output  8  number of published frames, wraps 255->0
error_count  output  8  frames that failed the checks, saturates at 255

Behaviour:
- Reset: state IDLE; bit count 0; shift register, shadow buffer, full, valid, overrun, frame_count and error_count all 0. A reset mid-frame discards that frame.
- States: IDLE, RECEIVE, CHECK.
- frame_begin, in any state: next state RECEIVE, bit count 0, full 0. frame_begin has priority over a bit_strobe in the same cycle; that bit is dropped.
- IDLE: bit_strobe is ignored.
- RECEIVE, on bit_strobe with count < FRAME_BITS:
  - shift bit_data in at the LSB of the frame register and increment the count;
  - when the count reaches FRAME_BITS, set full and go to CHECK next cycle.
- Strobes after full are ignored until the next frame_begin.
- CHECK lasts one cycle, then goes to IDLE. full stays 1 until the next frame_begin or reset.
- Check passes iff the preamble field equals PREAMBLE_VALUE and the constant field equals CONST_VALUE.
- Pass, hold = 0:
  - shadow byte k <= frame bits PAYLOAD_OFFSET+8k .. +7, with the first received bit in bit 7;
  - valid <= 1; frame_count increments.
- Pass, hold = 1: the shadow buffer is unchanged; overrun <= 1; frame_count is unchanged.
- Fail: error_count increments, saturating at 255; shadow, valid and frame_count are unchanged.
- A successful publish does not clear overrun; only reset clears it.
- Latency: last bit strobe in cycle N -> CHECK in N+1 -> new shadow contents and valid visible from N+2.
- read_data by address:
  - address < PAYLOAD_BYTES: shadow byte;
  - address == 2**ADDR_BITS-1: status byte {3'b0, hold, last_check_ok, overrun, valid, full};
  - any other address: 8'h00.
- last_check_ok: result of the most recent CHECK; reset value 0.
- hold changes take effect in the cycle they are sampled. Reads are never blocked.

Test Plan:
- Good frame with default parameters, hold=0: preamble AAAAAAAA, constant 0DFFFFFE, payload bytes 01..0C. After two cycles, addresses 0..11 read 01..0C, address 15 reads 8'h0B, frame_count=1.
- Corrupted preamble (AAAAAAAB): shadow stays 0, valid=0, error_count=1, address 15 reads 8'h01. Repeat 300 times -> error_count holds at 255.
- Good frame A published, hold=1, then good frame B with different payload: reads still return A, overrun=1, frame_count=1. Release hold and send frame C -> C visible, frame_count=2, overrun still 1.
- frame_begin after 100 bits, then a full good frame: the frame decodes correctly. frame_begin coincident with a strobe: that bit is dropped and the frame still aligns.
- 200 strobes after frame_begin: extra bits ignored, exactly one CHECK, full=1 until the next frame_begin. Reset asserted at bit 150: all outputs 0 and state IDLE next cycle.
- 256 good frames: frame_count wraps to 0 and valid stays 1. Addresses 12..14 read 00.
